debounce_scheduler: RTL and testbench
=====================================

Name: debounce_scheduler

Overview:
- Shares one debounce timer among N_BTN push-buttons using round-robin arbitration.
- Sits between the raw button pins and the display/counter logic that drives the 4-digit seven-segment display.
- Replaces per-button debounce counters with one counter plus per-button stable-state flops.
- Emits a debounced level and a one-cycle rising-edge tick per button.

Parameters:
- N_BTN, 2, number of buttons sharing the timer (2..8).
- DB_COUNT, 2_000_000, stability window in clk cycles (20 ms at 100 MHz).
- CNT_W, 21, timer width; must satisfy 2^CNT_W > DB_COUNT.

Ports:
- clk_amisha  in  1  system clock, rising edge.
- reset_amisha  in  1  asynchronous active-low reset.
- btn_in  in  N_BTN  raw button inputs.
- db_level  out  N_BTN  debounced stable level per button.
- db_tick  out  N_BTN  one-cycle pulse when db_level[i] commits 0->1.
- grant  out  N_BTN  one-hot: which button currently owns the timer; 0 when idle.
- busy  out  1  high while the timer is owned (state WAIT).

Behaviour:
- Reset (reset_amisha=0, async) forces:
  - db_level=0, db_tick=0, grant=0, busy=0.
  - cnt=0, rr_ptr=0, state=IDLE.
  - Sync flops (if present) cleared.
- raw[i] is btn_in[i], or its synchronised copy when the optional feature is enabled.
- pending[i] = (raw[i] != db_level[i]).
- FSM states: IDLE, WAIT. All outputs are registered.
- IDLE:
  - Search pending starting at rr_ptr, wrapping modulo N_BTN.
  - First hit i: sel<=i, grant<=onehot(i), cnt<=DB_COUNT-1, busy<=1, state<=WAIT.
  - No hit: remain in IDLE.
- WAIT, evaluated each cycle in priority order:
  - (a) raw[sel]==db_level[sel] (bounced back): abort. grant<=0, busy<=0, rr_ptr<=sel+1 mod N_BTN, state<=IDLE; db_level unchanged.
  - (b) cnt==0: commit. db_level[sel]<=raw[sel]; db_tick[sel]<=1 for one cycle if the new value is 1; grant<=0, busy<=0, rr_ptr<=sel+1 mod N_BTN, state<=IDLE.
  - (c) otherwise: cnt<=cnt-1.
- Latency:
  - Feature off: a clean change on btn_in is visible on db_level DB_COUNT+1 rising edges after the first sampling edge.
  - This breaks down as 1 IDLE grant edge plus DB_COUNT WAIT edges.
- Only the granted button is timed. Changes on other buttons stay pending and wait for their grant; they are never lost while the level persists.
- A non-granted button that changes and returns before its grant produces no event.
- Simultaneous pending buttons are served in rr order. One IDLE cycle always separates consecutive grants.
- Release commits (1->0) update db_level only; no tick.
- db_tick is 0 in every cycle except a 0->1 commit cycle.
- Reset asserted mid-WAIT aborts the cycle; no tick is emitted.
- N_BTN=1: rr_ptr stays 0.

Optional Feature:
- Macro: DEBOUNCE_SCHEDULER_SYNC_EN.
- Defined:
  - A 2-flop synchroniser per btn_in bit feeds raw; reset value 0.
  - Latency increases by 2 cycles, to DB_COUNT+3 edges.
- Undefined:
  - raw=btn_in directly; the source must already be synchronous.

Decomposition:
- Shared package debounce_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_WAIT=1'b1.
  - default DB_COUNT constant.
  - a simulation-shortened DB_COUNT_SIM=8.
- One natural sub-module: rr_pick. Combinational round-robin finder taking pending and rr_ptr, returning hit and index.
- Timer and FSM stay in the top module.

Test Plan (DB_COUNT=8, N_BTN=2, feature off unless noted):
- Reset: hold reset_amisha=0 with btn_in=2'b11 -> all outputs 0. Release -> grant=2'b01 next edge; db_level[0]=1 and db_tick=2'b01 on edge 9.
- Clean press btn_in=2'b01 -> busy high for 8 cycles; db_level=2'b01 at edge 9; db_tick[0] pulses exactly 1 cycle.
- Bounce: btn_in[0] toggles 1,0 inside the window -> abort on the cycle raw matches db_level; grant returns 0; no tick; a later stable press commits normally.
- Contention: btn_in 00->11 in one cycle -> btn0 commits at edge 9; grant=2'b10 at edge 10; btn1 commits at edge 18; ticks are 9 cycles apart.
- Release: from db_level=2'b01, set btn_in=2'b00 -> db_level[0]=0 after 9 edges; db_tick stays 0.
- Reset mid-WAIT (cnt=3) -> immediate clear, no tick. With DEBOUNCE_SCHEDULER_SYNC_EN, a clean press commits at edge 11.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants for the debounce scheduler: FSM encoding and stability windows.
package debounce_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT
  } state_t;

  // 20 ms at 100 MHz; the short window keeps simulations fast.
  localparam int DB_COUNT_DEF = 2_000_000;
  localparam int DB_COUNT_SIM = 8;

endpackage

// File: rtl/debounce_scheduler_rr_pick.sv
// Combinational round-robin finder: first set bit of pending at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_sum;

  // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit wins.
  assign w_dbl = {pending, pending};
  assign w_rot = N'(w_dbl >> rr_ptr);

  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        hit   = 1'b1;
        w_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
        if (w_sum >= (IDX_W + 1)'(N)) begin
          w_sum = w_sum - (IDX_W + 1)'(N);
        end
        idx = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// One shared debounce timer served round-robin across N_BTN buttons; registered level/tick/grant/busy.
// DEBOUNCE_SCHEDULER_SYNC_EN adds a 2-flop synchroniser per button ahead of the scheduler.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_BTN    = 2,
  parameter int DB_COUNT = DB_COUNT_DEF,
  parameter int CNT_W    = 21
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] db_level,
  output logic [N_BTN-1:0] db_tick,
  output logic [N_BTN-1:0] grant,
  output logic             busy
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_sel, w_sel_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_ptr_nxt;
  logic [N_BTN-1:0]   r_level, w_level_nxt;
  logic [N_BTN-1:0]   r_tick, w_tick_nxt;
  logic [N_BTN-1:0]   r_grant, w_grant_nxt;
  logic               r_busy, w_busy_nxt;

  logic [N_BTN-1:0]   w_raw;
  logic [N_BTN-1:0]   w_pending;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ptr_inc;

`ifdef DEBOUNCE_SCHEDULER_SYNC_EN
  logic [N_BTN-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = r_sync2;
`else
  assign w_raw = btn_in;
`endif

  assign w_pending = w_raw ^ r_level;
  assign w_ptr_inc = (r_sel == IDX_W'(N_BTN - 1)) ? '0 : r_sel + IDX_W'(1);

  rr_pick #(.N(N_BTN), .IDX_W(IDX_W)) u_rr_pick (
    .pending (w_pending),
    .rr_ptr  (r_rr_ptr),
    .hit     (w_hit),
    .idx     (w_idx)
  );

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_level  <= '0;
      r_tick   <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_level  <= w_level_nxt;
      r_tick   <= w_tick_nxt;
      r_grant  <= w_grant_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_rr_ptr;
    w_level_nxt = r_level;
    w_tick_nxt  = '0;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_sel_nxt   = w_idx;
          w_grant_nxt = N_BTN'(1) << w_idx;
          w_cnt_nxt   = CNT_W'(DB_COUNT - 1);
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A bounce back to the committed level beats an expiring timer.
        if (w_raw[r_sel] == r_level[r_sel]) begin
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = w_ptr_inc;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_level_nxt[r_sel] = w_raw[r_sel];
          w_tick_nxt[r_sel]  = w_raw[r_sel];
          w_grant_nxt        = '0;
          w_busy_nxt         = 1'b0;
          w_ptr_nxt          = w_ptr_inc;
          w_state_nxt        = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign db_level = r_level;
  assign db_tick  = r_tick;
  assign grant    = r_grant;
  assign busy     = r_busy;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Randomised scoreboard bench for debounce_scheduler against a timestamp-based reference model.
module tb_debounce_scheduler;
  import debounce_pkg::*;

  localparam int N  = 2;
  localparam int DB = DB_COUNT_SIM;
  localparam int W  = 3 * N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic [N-1:0] db_level, db_tick, grant;
  logic         busy;

  debounce_scheduler #(.N_BTN(N), .DB_COUNT(DB), .CNT_W(4)) dut (
    .clk_amisha   (clk),
    .reset_amisha (rst_n),
    .btn_in       (btn),
    .db_level     (db_level),
    .db_tick      (db_tick),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [W-1:0] expq[$];
  bit mon_en = 1'b0;
  int ticks_seen = 0;

  // Model: owner is the button holding the timer (-1 idle), start is the grant cycle.
  logic [N-1:0] m_level, m_tick, m_s1, m_s2;
  int m_owner, m_start, m_ptr, m_cyc, m_ticks;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (level,tick,grant,busy) at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic void model_reset();
    m_level = '0; m_tick = '0; m_s1 = '0; m_s2 = '0;
    m_owner = -1; m_start = 0; m_ptr = 0; m_cyc = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] b);
    logic [N-1:0] r, g;
    logic ri;
    int i;
`ifdef DEBOUNCE_SCHEDULER_SYNC_EN
    r = m_s2; m_s2 = m_s1; m_s1 = b;
`else
    r = b;
`endif
    m_tick = '0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (m_owner < 0 && bit_of(r, i) != bit_of(m_level, i)) begin
          m_owner = i;
          m_start = m_cyc;
        end
      end
    end else begin
      i  = m_owner;
      ri = bit_of(r, i);
      if (ri == bit_of(m_level, i)) begin
        m_owner = -1;
        m_ptr = (i + 1) % N;
      end else if (m_cyc - m_start == DB) begin
        m_level = (m_level & ~(N'(1) << i)) | (N'(ri) << i);
        m_tick  = N'(ri) << i;
        if (ri) m_ticks++;
        m_owner = -1;
        m_ptr = (i + 1) % N;
      end
    end
    m_cyc++;
    g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    expq.push_back({m_level, m_tick, g, (m_owner >= 0)});
  endfunction

  // Called at a negedge; applies v for the given number of rising edges.
  task automatic drive(input logic [N-1:0] v, input int cycles);
    repeat (cycles) begin
      btn = v;
      model_step(v);
      @(negedge clk);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (expq.size() == 0) begin
        check("queue_underflow", {db_level, db_tick, grant, busy}, 'x);
      end else begin
        check("cycle", {db_level, db_tick, grant, busy}, expq.pop_front());
        ticks_seen += $countones(db_tick);
      end
    end
  end

  initial begin
    model_reset();
    m_ticks = 0;
    btn = 2'b11;
    repeat (3) @(negedge clk);
    check("reset_outputs", {db_level, db_tick, grant, busy}, '0);

    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(2'b11, 25);
    drive(2'b00, 25);
    drive(2'b01, 12);
    drive(2'b00, 12);
    drive(2'b01, 3);
    drive(2'b00, 2);
    drive(2'b01, 14);
    drive(2'b00, 12);
    drive(2'b11, 24);
    for (int s = 0; s < 250; s++) begin
      drive(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(1, 14));
    end

    drive(btn, 25);
    drive(btn ^ 2'b01, 5);
    mon_en = 1'b0;
    check("busy_before_reset", {db_level, db_tick, grant, busy},
          {db_level, db_tick, grant, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", {db_level, db_tick, grant, busy}, '0);
    @(posedge clk);
    #1 check("held_reset_no_tick", {db_level, db_tick, grant, busy}, '0);
    expq.delete();
    model_reset();

    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    drive(2'b01, 15);
    drive(2'b00, 12);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    total++;
    if (ticks_seen != m_ticks) begin
      bad++;
      $display("FAIL tick_count: got %0d want %0d", ticks_seen, m_ticks);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
